// File: rtl/cpu_test_monitor.sv
// End-of-test monitor: detects CPU halt (pc parked at END_PC) or a cycle timeout,
// then walks a programmable list of register/memory checks over a debug read port.
module cpu_test_monitor #(
  parameter int PC_WIDTH       = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int N_CHECKS       = 8,
  parameter int END_PC         = 20,
  parameter int HALT_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int IW = $clog2(N_CHECKS),
  localparam int CW = $clog2(N_CHECKS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic                  cfg_we,
  input  logic [IW-1:0]         cfg_index,
  input  logic                  cfg_is_mem,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_expected,
  input  logic                  cfg_valid,
  output logic                  dbg_req,
  output logic                  dbg_is_mem,
  output logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CW-1:0]         mismatch_count,
  output logic [IW-1:0]         first_fail_index
);

  localparam int CCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SCW = $clog2(HALT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RUN, CHK_REQ, CHK_WAIT, DONE} state_t;

  state_t                state;
  logic [CCW-1:0]        cycle_cnt;
  logic [SCW-1:0]        stable_cnt;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         nidx;
  logic                  pc_end;
  logic                  halt_now;
  logic                  last_idx;
  logic                  miss;
  logic                  cfg_open;

  logic [N_CHECKS-1:0]   ent_valid;
  logic [N_CHECKS-1:0]   ent_is_mem;
  logic [ADDR_WIDTH-1:0] ent_addr [N_CHECKS];
  logic [DATA_WIDTH-1:0] ent_exp  [N_CHECKS];

  // nidx is the entry the next CHK_REQ will present; the debug request is
  // registered one cycle early from it so dbg_req is high exactly in CHK_REQ.
  always_comb begin
    nidx     = (state == RUN) ? '0 : idx + IW'(1);
    pc_end   = (pc == PC_WIDTH'(END_PC));
    halt_now = pc_end && (stable_cnt == SCW'(HALT_CYCLES - 1));
    last_idx = (idx == IW'(N_CHECKS - 1));
    miss     = (dbg_rdata != ent_exp[idx]);
    cfg_open = (state == IDLE) || (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset && cfg_we && cfg_open) begin
      ent_is_mem[cfg_index] <= cfg_is_mem;
      ent_addr[cfg_index]   <= cfg_addr;
      ent_exp[cfg_index]    <= cfg_expected;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      ent_valid        <= '0;
      cycle_cnt        <= '0;
      stable_cnt       <= '0;
      idx              <= '0;
      dbg_req          <= 1'b0;
      dbg_is_mem       <= 1'b0;
      dbg_addr         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      timeout          <= 1'b0;
      mismatch_count   <= '0;
      first_fail_index <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (cfg_we) ent_valid[cfg_index] <= cfg_valid;
          if (start) begin
            state            <= RUN;
            busy             <= 1'b1;
            done             <= 1'b0;
            cycle_cnt        <= '0;
            stable_cnt       <= '0;
            mismatch_count   <= '0;
            first_fail_index <= '0;
            timeout          <= 1'b0;
            pass             <= 1'b0;
          end
        end
        RUN: begin
          cycle_cnt  <= cycle_cnt + CCW'(1);
          stable_cnt <= pc_end ? stable_cnt + SCW'(1) : '0;
          if (halt_now) begin
            state      <= CHK_REQ;
            idx        <= nidx;
            dbg_req    <= ent_valid[nidx];
            dbg_is_mem <= ent_is_mem[nidx];
            dbg_addr   <= ent_addr[nidx];
          end else if (cycle_cnt == CCW'(TIMEOUT_CYCLES - 1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        CHK_REQ: begin
          if (ent_valid[idx]) begin
            state   <= CHK_WAIT;
            dbg_req <= 1'b0;
          end else if (last_idx) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (mismatch_count == '0);
          end else begin
            idx        <= nidx;
            dbg_req    <= ent_valid[nidx];
            dbg_is_mem <= ent_is_mem[nidx];
            dbg_addr   <= ent_addr[nidx];
          end
        end
        CHK_WAIT: begin
          if (miss) begin
            mismatch_count <= mismatch_count + CW'(1);
            if (mismatch_count == '0) first_fail_index <= idx;
          end
          if (last_idx) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !miss && (mismatch_count == '0);
          end else begin
            state      <= CHK_REQ;
            idx        <= nidx;
            dbg_req    <= ent_valid[nidx];
            dbg_is_mem <= ent_is_mem[nidx];
            dbg_addr   <= ent_addr[nidx];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_test_monitor.sv
// Bench for cpu_test_monitor: table of lab-9 style runs plus hand sequences for
// timeout, halt glitch/priority, reset mid-check and busy-ignore behaviour.
module tb_cpu_test_monitor;

  localparam int PCW   = 32;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NC    = 8;
  localparam int ENDPC = 20;
  localparam int HC    = 4;
  localparam int TO    = 50;
  localparam int IW    = $clog2(NC);
  localparam int CW    = $clog2(NC + 1);

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [PCW-1:0] pc = '0;
  logic           cfg_we = 1'b0;
  logic [IW-1:0]  cfg_index = '0;
  logic           cfg_is_mem = 1'b0;
  logic [AW-1:0]  cfg_addr = '0;
  logic [DW-1:0]  cfg_expected = '0;
  logic           cfg_valid = 1'b0;
  logic           dbg_req, dbg_is_mem;
  logic [AW-1:0]  dbg_addr;
  logic [DW-1:0]  dbg_rdata;
  logic           busy, done, pass, timeout;
  logic [CW-1:0]  mismatch_count;
  logic [IW-1:0]  first_fail_index;

  always #5 clock = ~clock;

  cpu_test_monitor #(
    .PC_WIDTH(PCW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_CHECKS(NC),
    .END_PC(ENDPC), .HALT_CYCLES(HC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .pc(pc),
    .cfg_we(cfg_we), .cfg_index(cfg_index), .cfg_is_mem(cfg_is_mem),
    .cfg_addr(cfg_addr), .cfg_expected(cfg_expected), .cfg_valid(cfg_valid),
    .dbg_req(dbg_req), .dbg_is_mem(dbg_is_mem), .dbg_addr(dbg_addr),
    .dbg_rdata(dbg_rdata), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .mismatch_count(mismatch_count),
    .first_fail_index(first_fail_index)
  );

  // CPU-side model: register file and data memory answer one cycle after dbg_req,
  // with junk on the bus at any other time.
  logic [DW-1:0] rf   [32];
  logic [DW-1:0] dmem [32];
  int req_cnt = 0;

  always @(posedge clock) begin
    if (dbg_req) begin
      dbg_rdata <= dbg_is_mem ? dmem[dbg_addr] : rf[dbg_addr];
      req_cnt   <= req_cnt + 1;
    end else begin
      dbg_rdata <= $urandom;
    end
  end

  typedef struct {
    int lat; bit tmo; bit pass; int mm; int ffi; int nreq;
  } exp_t;

  typedef struct {
    logic [2:0] mask; int base;
    logic [DW-1:0] r9; logic [DW-1:0] r18; logic [DW-1:0] m16;
    int lat; bit pass; int mm; int ffi;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[8];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input int idx, input bit is_mem, input int addr,
                           input logic [DW-1:0] ev, input bit v);
    cfg_we = 1'b1; cfg_index = IW'(idx); cfg_is_mem = is_mem;
    cfg_addr = AW'(addr); cfg_expected = ev; cfg_valid = v;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic load_lab9(input int base, input logic [2:0] mask);
    for (int i = 0; i < NC; i++) cfg_write(i, 1'b0, 0, '0, 1'b0);
    cfg_write(base,     1'b0, 9,  32'd1,  mask[0]);
    cfg_write(base + 1, 1'b0, 18, 32'd12, mask[1]);
    cfg_write(base + 2, 1'b1, 16, 32'd12, mask[2]);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " timeout"}, timeout, 0);
    chk({tag, " mismatch_count"}, mismatch_count, 0);
    chk({tag, " first_fail_index"}, first_fail_index, 0);
    chk({tag, " dbg_req"}, dbg_req, 0);
    chk({tag, " dbg_is_mem"}, dbg_is_mem, 0);
    chk({tag, " dbg_addr"}, dbg_addr, 0);
  endtask

  task automatic check_result(input int n, input int r0);
    exp_t x;
    x = sbq.pop_front();
    chk("latency", n, x.lat);
    chk("done", done, 1);
    chk("busy at done", busy, 0);
    chk("timeout", timeout, x.tmo);
    chk("pass", pass, x.pass);
    chk("mismatch_count", mismatch_count, x.mm);
    if (x.mm != 0) chk("first_fail_index", first_fail_index, x.ffi);
    chk("dbg_req count", req_cnt - r0, x.nreq);
  endtask

  // Latency is counted in clock edges from the (final) drive of pc = END_PC.
  task automatic run_halt(input int pre, input bit glitch, input bit disturb,
                          input bit cws, input exp_t e);
    int n;
    int r0;
    sbq.push_back(e);
    r0 = req_cnt;
    pc = '0;
    if (cws) begin
      cfg_we = 1'b1; cfg_index = IW'(2); cfg_is_mem = 1'b1;
      cfg_addr = AW'(16); cfg_expected = 32'd11; cfg_valid = 1'b1;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_we = 1'b0;
    @(negedge clock);
    chk("busy in run", busy, 1);
    chk("done in run", done, 0);
    for (int i = 0; i < pre; i++) begin
      pc = PCW'(100 + i);
      step();
    end
    if (glitch) begin
      pc = PCW'(ENDPC);
      repeat (3) step();
      pc = '0;
      step();
    end
    pc = PCW'(ENDPC);
    n = 0;
    do begin
      start  = disturb && (n == 2 || n == 8);
      cfg_we = disturb && (n == 2);
      if (cfg_we) begin
        cfg_index = IW'(2); cfg_is_mem = 1'b1; cfg_addr = AW'(16);
        cfg_expected = 32'd99; cfg_valid = 1'b1;
      end
      step();
      n++;
      @(negedge clock);
    end while (!done && n < 100);
    start = 1'b0;
    cfg_we = 1'b0;
    check_result(n, r0);
  endtask

  task automatic run_timeout(input exp_t e);
    int n;
    int r0;
    sbq.push_back(e);
    r0 = req_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    do begin
      pc = PCW'(100 + n);
      step();
      n++;
      @(negedge clock);
    end while (!done && n < 100);
    check_result(n, r0);
  endtask

  task automatic set_lab9_mem(input logic [DW-1:0] r9, input logic [DW-1:0] r18,
                              input logic [DW-1:0] m16);
    rf[9] = r9; rf[18] = r18; dmem[16] = m16;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      dmem[i] = '0;
    end
    set_lab9_mem(32'd1, 32'd12, 32'd12);

    vt[0] = '{mask:3'b111, base:0, r9:1, r18:12, m16:12, lat:15, pass:1, mm:0, ffi:0};
    vt[1] = '{mask:3'b111, base:0, r9:1, r18:12, m16:11, lat:15, pass:0, mm:1, ffi:2};
    vt[2] = '{mask:3'b111, base:3, r9:0, r18:12, m16:11, lat:15, pass:0, mm:2, ffi:3};
    vt[3] = '{mask:3'b000, base:0, r9:0, r18:0,  m16:0,  lat:12, pass:1, mm:0, ffi:0};
    vt[4] = '{mask:3'b010, base:5, r9:1, r18:13, m16:12, lat:13, pass:0, mm:1, ffi:6};
    vt[5] = '{mask:3'b101, base:5, r9:7, r18:12, m16:0,  lat:14, pass:0, mm:2, ffi:5};
    vt[6] = '{mask:3'b100, base:5, r9:1, r18:12, m16:0,  lat:13, pass:0, mm:1, ffi:7};
    vt[7] = '{mask:3'b111, base:5, r9:1, r18:99, m16:12, lat:15, pass:0, mm:1, ffi:6};

    repeat (3) step();
    @(negedge clock);
    check_idle("reset");
    reset = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      set_lab9_mem(vt[i].r9, vt[i].r18, vt[i].m16);
      load_lab9(vt[i].base, vt[i].mask);
      run_halt(3, 1'b0, 1'b0, 1'b0,
               '{lat:vt[i].lat, tmo:1'b0, pass:vt[i].pass, mm:vt[i].mm,
                 ffi:vt[i].ffi, nreq:$countones(vt[i].mask)});
    end

    set_lab9_mem(32'd1, 32'd12, 32'd12);
    load_lab9(0, 3'b111);
    // pc at END_PC for 3 cycles, leaves, returns: halt needs 4 fresh cycles
    run_halt(2, 1'b1, 1'b0, 1'b0, '{lat:15, tmo:0, pass:1, mm:0, ffi:0, nreq:3});
    // 4th halt cycle coincides with RUN cycle TIMEOUT: halt wins
    run_halt(TO - HC, 1'b0, 1'b0, 1'b0, '{lat:15, tmo:0, pass:1, mm:0, ffi:0, nreq:3});
    // one cycle later the timeout fires first
    run_halt(TO - HC + 1, 1'b0, 1'b0, 1'b0, '{lat:3, tmo:1, pass:0, mm:0, ffi:0, nreq:0});
    run_timeout('{lat:TO, tmo:1, pass:0, mm:0, ffi:0, nreq:0});
    // start and cfg_we pulsed while busy must be ignored
    run_halt(3, 1'b0, 1'b1, 1'b0, '{lat:15, tmo:0, pass:1, mm:0, ffi:0, nreq:3});
    // cfg write in the start cycle is used by that run
    run_halt(3, 1'b0, 1'b0, 1'b1, '{lat:15, tmo:0, pass:0, mm:1, ffi:2, nreq:3});

    for (int i = 0; i < NC; i++) cfg_write(i, 1'b0, i + 1, 32'hDEAD0000 + DW'(i), 1'b1);
    run_halt(3, 1'b0, 1'b0, 1'b0, '{lat:20, tmo:0, pass:0, mm:8, ffi:0, nreq:8});

    load_lab9(0, 3'b111);
    start = 1'b1;
    step();
    start = 1'b0;
    pc = PCW'(ENDPC);
    n = 0;
    do begin
      step();
      n++;
      @(negedge clock);
    end while (!dbg_req && n < 30);
    chk("reached CHK_REQ", dbg_req, 1);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clock);
    check_idle("reset mid-check");
    run_halt(3, 1'b0, 1'b0, 1'b0, '{lat:12, tmo:0, pass:1, mm:0, ffi:0, nreq:0});
    load_lab9(0, 3'b111);
    run_halt(3, 1'b0, 1'b0, 1'b0, '{lat:15, tmo:0, pass:1, mm:0, ffi:0, nreq:3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_test_monitor.md
Name: cpu_test_monitor

Overview:
- Parametrised, synthesizable successor to the per-lab CPU testbenches.
- Watches the CPU program counter for a halt condition (PC parked at END_PC) or a cycle timeout. It then reads back a configurable list of expected register-file and data-memory values through a debug read port and reports pass/fail.
- Sits beside the CPU in every lab bench, and on FPGA, replacing hand-written end-of-test checks.

Parameters:
- PC_WIDTH, 32, width of the pc input.
- DATA_WIDTH, 32, width of expected and read-back data.
- ADDR_WIDTH, 5, debug address width (register index or data-memory word index).
- N_CHECKS, 8, number of check entries; must be at least 2.
- END_PC, 20, PC value that marks program end.
- HALT_CYCLES, 4, consecutive cycles with pc == END_PC required to declare halt; must be at least 1.
- TIMEOUT_CYCLES, 1000, maximum RUN cycles before the timeout verdict.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- pc  in  PC_WIDTH  CPU program counter.
- cfg_we  in  1  check-entry write strobe; ignored while busy.
- cfg_index  in  clog2(N_CHECKS)  entry being written.
- cfg_is_mem  in  1  0 = register-file check, 1 = data-memory check.
- cfg_addr  in  ADDR_WIDTH  register or memory word index.
- cfg_expected  in  DATA_WIDTH  expected value.
- cfg_valid  in  1  written into the entry's valid bit; 0 disables the entry.
- dbg_req  out  1  debug read request.
- dbg_is_mem  out  1  debug target select.
- dbg_addr  out  ADDR_WIDTH  debug read address.
- dbg_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after dbg_req.
- busy  out  1  high in RUN, CHK_REQ and CHK_WAIT.
- done  out  1  high in DONE.
- pass  out  1  verdict; meaningful only when done = 1.
- timeout  out  1  run ended by timeout.
- mismatch_count  out  clog2(N_CHECKS+1)  failed checks.
- first_fail_index  out  clog2(N_CHECKS)  lowest failing entry index; meaningful only when mismatch_count != 0.

Behaviour:
- Reset (reset = 0 at a clock edge):
  - State becomes IDLE.
  - All entry valid bits, counters and outputs clear to 0.
  - Reset overrides any state, including mid-check.
- IDLE / DONE:
  - cfg_we writes entry[cfg_index] in one cycle.
  - start moves to RUN on the next edge and clears cycle_cnt, stable_cnt, mismatch_count, first_fail_index, timeout and pass.
  - If start and cfg_we are high in the same cycle, the cfg write happens first and is visible to this run.
- RUN:
  - cycle_cnt increments every cycle.
  - stable_cnt increments when pc == END_PC; otherwise it resets to 0.
  - When stable_cnt + 1 == HALT_CYCLES with pc == END_PC: go to CHK_REQ with idx = 0.
  - Else when cycle_cnt + 1 == TIMEOUT_CYCLES: go to DONE with timeout = 1, pass = 0. No checks are performed.
  - If halt and timeout occur in the same cycle, halt wins.
- CHK_REQ:
  - If entry[idx] is valid: dbg_req = 1, dbg_is_mem and dbg_addr taken from the entry; go to CHK_WAIT.
  - If entry[idx] is invalid: dbg_req = 0; go to the next idx, or to DONE if idx is the last entry.
- CHK_WAIT:
  - Compare dbg_rdata with the entry's expected value.
  - On mismatch: mismatch_count increments. If this is the first mismatch, first_fail_index is set to idx.
  - Go to CHK_REQ with idx + 1, or to DONE after idx = N_CHECKS - 1.
- DONE entry: pass = 1 iff timeout = 0 and mismatch_count = 0 (including the final compare). All outputs hold until start or reset.
- Timing:
  - Each valid entry costs 2 cycles; each invalid entry costs 1 cycle.
  - Latency from halt detection to done = 2 × valid entries + invalid entries.
- Outputs and cfg/start rules:
  - All outputs are registered.
  - dbg_req is low outside CHK_REQ.
  - start while busy is ignored, and cfg_we while busy is ignored.
- A run with no valid entries, halted by pc, gives pass = 1.

Test Plan:
- Lab 9 program, halt check: entries {reg 9 = 1, reg 18 = 12, mem 16 = 12}, pc reaching 20 and held there. Required: done, pass = 1, mismatch_count = 0; done rises 4 + 6 + 5 cycles after pc first equals 20 (N_CHECKS = 8, 3 valid entries).
- Mismatch reporting: corrupt mem 16 to 11. Required: pass = 0, mismatch_count = 1, first_fail_index = 2.
- Timeout: TIMEOUT_CYCLES = 50, pc never reaches 20. Required: done at RUN cycle 50, timeout = 1, pass = 0, dbg_req never asserted.
- Halt vs. timeout priority and glitch: pc equals 20 for 3 cycles, leaves, then returns and holds. Required: halt declared only after 4 consecutive cycles. With the halt landing exactly on cycle TIMEOUT_CYCLES, required: timeout = 0 and checks run.
- Reset and ignore rules: reset = 0 during CHK_WAIT. Required: IDLE, all outputs 0, entries invalid. After reconfiguring and pulsing start, the rerun passes. start and cfg_we pulses issued while busy have no effect.
